node_feeder: RTL and testbench
==============================

Name: node_feeder

Overview:
Upstream stage of the neural-network node. Accepts a serial stream of (x, w) fixed-point pairs, one pair per beat, plus the node bias. Packs sx pairs into the concatenated nx/nw buses and the bias b that the node consumes, then presents them with a valid/ready handshake. Two-bank ping-pong buffering lets one vector fill while the previous one is held for the node, so the block sustains one pair per cycle.

Parameters:
sx, 2, number of (x, w) pairs per vector; must match the sx of the node it feeds; sx >= 1
n, `n (fixed_point.vh), word width; derived (localparam), not overridable
f, `f (fixed_point.vh), fraction bits; derived (localparam), used only by the bench
i, `i (fixed_point.vh), integer bits; derived (localparam), used only by the bench

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_x  in  n  signed input x, i.f fixed point
in_w  in  n  signed weight w, i.f fixed point
in_b  in  n  signed bias; sampled only on the first beat of a vector
in_last  in  1  marks the final beat of a vector
out_valid  out  1  packed vector available
out_ready  in  1  consumer accepts the vector
nx  out  n*sx  packed x; beat k goes to nx[k*n +: n], LSB slice first
nw  out  n*sx  packed w; same slice mapping as nx
b  out  n  bias of the presented vector
err_len  out  1  one-cycle pulse on a vector-length violation

Behaviour:
- A beat transfers when in_valid && in_ready. A vector transfers when out_valid && out_ready.
- Reset (asynchronous assert, synchronous release) forces:
  - both banks EMPTY; write bank = 0; read bank = 0; beat counter = 0
  - out_valid = 0; in_ready = 1; nx = 0; nw = 0; b = 0; err_len = 0
  - any partially filled or held vector is discarded.
- Each bank has three states: EMPTY, FILLING and FULL. The banks alternate, and the write and read pointers each toggle on completion of their own side.
- Input side, per accepted beat:
  - store in_x and in_w at the slice given by the beat counter (0..sx-1)
  - on counter == 0, latch in_b and move the bank EMPTY -> FILLING.
- Vector completion:
  - Completion happens on the beat with counter == sx-1, or on an early in_last.
  - The bank moves to FULL, the counter clears and the write pointer toggles.
- Length errors:
  - Early in_last (counter < sx-1): slices above the counter are zero-filled, err_len pulses the next cycle, and the vector completes normally.
  - in_last = 0 on the beat with counter == sx-1: the vector completes and err_len pulses. The block enters DROP: in_ready = 1, beats are accepted and discarded, and DROP exits after the accepted beat with in_last = 1 (that beat is also discarded).
- in_ready = 1 when the write bank is not FULL, or when in DROP.
  - in_ready is derived from registered state only; there is no combinational path from out_ready to in_ready.
- Output side:
  - out_valid = 1 when the read bank is FULL.
  - nx, nw and b are driven from registers and change only when out_valid is low or a vector transfer occurs.
  - On a vector transfer the read bank goes to EMPTY and the read pointer toggles.
- Timing: out_valid rises on the cycle after the completing beat. Sustained throughput is one beat per cycle and one vector per sx cycles.
- Simultaneous completion of one bank and transfer of the other in the same cycle is legal. Both updates take effect, and out_valid stays high with the new vector the next cycle.
- When both banks are FULL, in_ready = 0. It returns to 1 on the cycle after a vector transfer.
- Values pass through unchanged; there is no arithmetic, saturation or truncation.
- sx = 1: every beat completes a vector. Early in_last cannot occur; a beat with in_last = 0 completes the vector and then enters DROP.

Decomposition:
- fixed_point.vh provides `n, `f, `i; no new macros are added.
- Sub-module feeder_bank holds one bank:
  - registers: n*sx x, n*sx w, n bias, 2-bit state
  - ports: slice write with index, bias write, zero-fill-above-index, set FULL, clear
- node_feeder instantiates two feeder_bank instances and holds the pointers, beat counter, DROP flag and output mux registers.

Test Plan:
1. Basic vector, sx=2, n=32, f=24, out_ready = 1.
   - Stimulus: beat 0 x=0x01000000 (1.0), w=0x00800000 (0.5), b=0xFF800000 (-0.5); beat 1 x=0x02000000, w=0xFF000000, in_last = 1.
   - Response: one cycle after beat 1, out_valid = 1, nx=0x02000000_01000000, nw=0xFF000000_00800000, b=0xFF800000, err_len = 0.
2. Back-pressure: hold out_ready = 0 and stream three vectors.
   - Two vectors are accepted; in_ready drops after the 4th beat.
   - nx stays frozen until out_ready = 1; the third vector is then accepted and all three emerge in order.
3. Sustained throughput: out_ready = 1, 10 vectors back-to-back.
   - in_ready is never low; out_valid pulses every 2 cycles with correct data.
4. Early in_last on beat 0 (x=0x00400000).
   - Response: nx=0x00000000_00400000, upper nw slice = 0, err_len pulses once.
5. Missing in_last: 5 beats, in_last only on beat 4.
   - Response: vector 0 carries beats 0–1, err_len pulses once, beats 2–4 are discarded.
   - A following clean vector is packed correctly.
6. Reset mid-operation: assert rst_n low after beat 0 with one vector already FULL.
   - out_valid = 0, nx/nw/b = 0 and in_ready = 1 immediately (asynchronous).
   - After release, a fresh vector packs from slice 0.

Source files
------------

// File: rtl/node_feeder_pkg.sv
// Shared word format and bank state encoding for the node feeder.
// Words are signed i.f fixed point; the feeder only moves them, never computes on them.
package node_feeder_pkg;

  localparam int FP_N = 32;
  localparam int FP_F = 24;
  localparam int FP_I = FP_N - FP_F;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Width of a slice index; kept at least one bit so sx = 1 still has a counter.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/feeder_bank.sv
// One ping-pong bank: packed x/w slices, the vector bias and the bank state.
// Next-state values are exported so the output stage can capture a vector on the edge it completes.
module feeder_bank
  import node_feeder_pkg::*;
#(
  parameter  int sx = 2,
  localparam int n  = FP_N,
  localparam int cw = idx_width(sx)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [cw-1:0]    wr_idx,
  input  logic [n-1:0]     wr_x,
  input  logic [n-1:0]     wr_w,
  input  logic             bias_en,
  input  logic [n-1:0]     wr_bias,
  input  logic             zero_en,
  input  logic             set_full,
  input  logic             clear,
  output bank_state_t      state,
  output bank_state_t      state_nxt,
  output logic [n*sx-1:0]  x_nxt,
  output logic [n*sx-1:0]  w_nxt,
  output logic [n-1:0]     bias_nxt
);

  logic [n*sx-1:0] x_q;
  logic [n*sx-1:0] w_q;
  logic [n-1:0]    bias_q;

  // A slice above the written index is zeroed when a vector ends early, so stale data never leaks out.
  always_comb begin
    x_nxt     = x_q;
    w_nxt     = w_q;
    bias_nxt  = bias_q;
    state_nxt = state;
    for (int k = 0; k < sx; k++) begin
      if (wr_en && (wr_idx == cw'(k))) begin
        x_nxt[k*n +: n] = wr_x;
        w_nxt[k*n +: n] = wr_w;
      end else if (zero_en && (k > int'(wr_idx))) begin
        x_nxt[k*n +: n] = '0;
        w_nxt[k*n +: n] = '0;
      end
    end
    if (bias_en) begin
      bias_nxt  = wr_bias;
      state_nxt = BANK_FILLING;
    end
    if (set_full) state_nxt = BANK_FULL;
    if (clear)    state_nxt = BANK_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      w_q    <= '0;
      bias_q <= '0;
      state  <= BANK_EMPTY;
    end else begin
      x_q    <= x_nxt;
      w_q    <= w_nxt;
      bias_q <= bias_nxt;
      state  <= state_nxt;
    end
  end

endmodule

// File: rtl/node_feeder.sv
// Packs a serial (x, w) beat stream into sx-wide vectors for the node,
// double-buffered across two banks so a new vector fills while the previous one waits.
module node_feeder
  import node_feeder_pkg::*;
#(
  parameter  int sx = 2,
  localparam int n  = FP_N,
  localparam int cw = idx_width(sx)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     in_x,
  input  logic [n-1:0]     in_w,
  input  logic [n-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n*sx-1:0]  nx,
  output logic [n*sx-1:0]  nw,
  output logic [n-1:0]     b,
  output logic             err_len
);

  logic            wr_ptr;
  logic            rd_ptr;
  logic            drop;
  logic [cw-1:0]   cnt;

  bank_state_t     st     [2];
  bank_state_t     st_nxt [2];
  logic [n*sx-1:0] x_nxt  [2];
  logic [n*sx-1:0] w_nxt  [2];
  logic [n-1:0]    b_nxt  [2];

  logic accept;
  logic write;
  logic at_end;
  logic complete;
  logic early;
  logic overrun;
  logic transfer;
  logic rd_sel;
  logic load;

  // in_ready looks only at registered state, never at out_ready.
  assign in_ready  = drop || (st[wr_ptr] != BANK_FULL);
  assign out_valid = (st[rd_ptr] == BANK_FULL);
  assign transfer  = out_valid && out_ready;

  assign accept   = in_valid && in_ready;
  assign write    = accept && !drop;
  assign at_end   = (cnt == cw'(sx - 1));
  assign complete = write && (at_end || in_last);
  assign early    = write && in_last && !at_end;
  assign overrun  = write && at_end && !in_last;

  for (genvar g = 0; g < 2; g++) begin : g_bank
    feeder_bank #(.sx(sx)) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (write && (wr_ptr == 1'(g))),
      .wr_idx    (cnt),
      .wr_x      (in_x),
      .wr_w      (in_w),
      .bias_en   (write && (cnt == '0) && (wr_ptr == 1'(g))),
      .wr_bias   (in_b),
      .zero_en   (early && (wr_ptr == 1'(g))),
      .set_full  (complete && (wr_ptr == 1'(g))),
      .clear     (transfer && (rd_ptr == 1'(g))),
      .state     (st[g]),
      .state_nxt (st_nxt[g]),
      .x_nxt     (x_nxt[g]),
      .w_nxt     (w_nxt[g]),
      .bias_nxt  (b_nxt[g])
    );
  end

  // Capture the bank that will be presented next, but only once it is full,
  // so the output holds steady whenever a vector is on offer.
  always_comb begin
    rd_sel = rd_ptr;
    if (transfer) rd_sel = ~rd_ptr;
    load = (!out_valid || transfer) && (st_nxt[rd_sel] == BANK_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= '0;
      drop    <= 1'b0;
      err_len <= 1'b0;
      nx      <= '0;
      nw      <= '0;
      b       <= '0;
    end else begin
      err_len <= early || overrun;
      if (complete) begin
        cnt    <= '0;
        wr_ptr <= ~wr_ptr;
      end else if (write) begin
        cnt <= cnt + 1'b1;
      end
      // An overlong vector leaves the rest of its beats to be swallowed up to its in_last.
      if (overrun) begin
        drop <= 1'b1;
      end else if (accept && drop && in_last) begin
        drop <= 1'b0;
      end
      if (transfer) rd_ptr <= ~rd_ptr;
      if (load) begin
        nx <= x_nxt[rd_sel];
        nw <= w_nxt[rd_sel];
        b  <= b_nxt[rd_sel];
      end
    end
  end

endmodule

// File: tb/tb_node_feeder.sv
// Directed bench for node_feeder (sx = 2): table of single vectors plus
// hand-written back-pressure, throughput, length-error and reset sequences.
module tb_node_feeder;
  import node_feeder_pkg::*;

  localparam int SX = 2;
  localparam int N  = FP_N;
  localparam int W  = N * SX;

  typedef struct {
    logic [N-1:0] x0;
    logic [N-1:0] w0;
    logic [N-1:0] x1;
    logic [N-1:0] w1;
    logic [N-1:0] bias;
    logic         single;
    logic [W-1:0] expNx;
    logic [W-1:0] expNw;
    logic         expErr;
  } vec_t;

  typedef struct {
    logic [W-1:0] nx;
    logic [W-1:0] nw;
    logic [N-1:0] b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] in_x = '0;
  logic [N-1:0] in_w = '0;
  logic [N-1:0] in_b = '0;
  logic         in_ready;
  logic         out_valid;
  logic         err_len;
  logic [W-1:0] nx;
  logic [W-1:0] nw;
  logic [N-1:0] b;

  int compared = 0;
  int mismatched = 0;
  int transfers = 0;
  int errPulses = 0;
  int stalls = 0;
  exp_t scoreboard[$];
  vec_t vectors[5];

  node_feeder #(.sx(SX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .nx        (nx),
    .nw        (nw),
    .b         (b),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
    end
  endtask

  // Drives one beat on a falling edge and returns once it has been accepted.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [N-1:0] w,
                               input logic [N-1:0] bias, input logic last);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = x;
    in_w = w;
    in_b = bias;
    in_last = last;
    while (!in_ready && waited < 50) begin
      stalls++;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) checkOutput("beat_accept_timeout", W'(in_ready), W'(1));
    @(posedge clk);
  endtask

  task automatic goIdle(input int cycles);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (cycles - 1) @(negedge clk);
  endtask

  task automatic pushExp(input logic [W-1:0] ex, input logic [W-1:0] ew, input logic [N-1:0] eb);
    exp_t e;
    e.nx = ex;
    e.nw = ew;
    e.b = eb;
    scoreboard.push_back(e);
  endtask

  // Scoreboard: every accepted vector must match the oldest expected one.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (err_len) errPulses++;
      if (out_valid && out_ready) begin
        transfers++;
        if (scoreboard.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_vector: actual nx %h, required no transfer", nx);
        end else begin
          exp_t e;
          e = scoreboard.pop_front();
          checkOutput("sb_nx", nx, e.nx);
          checkOutput("sb_nw", nw, e.nw);
          checkOutput("sb_b", W'(b), W'(e.b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int errStart;
    int xferStart;
    logic [N-1:0] bx [5];

    vectors[0] = '{32'h01000000, 32'h00800000, 32'h02000000, 32'hFF000000, 32'hFF800000, 1'b0,
                   64'h02000000_01000000, 64'hFF000000_00800000, 1'b0};
    vectors[1] = '{32'hFFFFFFFF, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b0,
                   64'h7FFFFFFF_FFFFFFFF, 64'h80000000_00000001, 1'b0};
    vectors[2] = '{32'h00400000, 32'h00C00000, 32'h0, 32'h0, 32'h00100000, 1'b1,
                   64'h00000000_00400000, 64'h00000000_00C00000, 1'b1};
    vectors[3] = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h80000000, 1'b1,
                   64'h00000000_80000000, 64'h00000000_7FFFFFFF, 1'b1};
    vectors[4] = '{32'hFF000000, 32'hFE800000, 32'h00000000, 32'h12345678, 32'h00000000, 1'b0,
                   64'h00000000_FF000000, 64'h12345678_FE800000, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset_out_valid", W'(out_valid), W'(0));
    checkOutput("reset_in_ready", W'(in_ready), W'(1));
    checkOutput("reset_nx", nx, '0);
    checkOutput("reset_nw", nw, '0);
    checkOutput("reset_b", W'(b), '0);
    checkOutput("reset_err_len", W'(err_len), W'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Single vectors, including early in_last whose upper slices must read as zero.
    for (int e = 0; e < 5; e++) begin
      pushExp(vectors[e].expNx, vectors[e].expNw, vectors[e].bias);
      applyStimulus(vectors[e].x0, vectors[e].w0, vectors[e].bias, vectors[e].single);
      if (!vectors[e].single) applyStimulus(vectors[e].x1, vectors[e].w1, ~vectors[e].bias, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      checkOutput($sformatf("vec%0d_out_valid", e), W'(out_valid), W'(1));
      checkOutput($sformatf("vec%0d_err_len", e), W'(err_len), W'(vectors[e].expErr));
      checkOutput($sformatf("vec%0d_nx", e), nx, vectors[e].expNx);
      checkOutput($sformatf("vec%0d_nw", e), nw, vectors[e].expNw);
      checkOutput($sformatf("vec%0d_b", e), W'(b), W'(vectors[e].bias));
      goIdle(2);
    end

    // Back-pressure: two vectors fill both banks, the third waits.
    out_ready = 1'b0;
    pushExp(64'h00000002_00000001, 64'h00000012_00000011, 32'h000000A0);
    pushExp(64'h00000004_00000003, 64'h00000014_00000013, 32'h000000B0);
    pushExp(64'h00000006_00000005, 64'h00000016_00000015, 32'h000000C0);
    applyStimulus(32'h1, 32'h11, 32'hA0, 1'b0);
    applyStimulus(32'h2, 32'h12, 32'hA0, 1'b1);
    applyStimulus(32'h3, 32'h13, 32'hB0, 1'b0);
    applyStimulus(32'h4, 32'h14, 32'hB0, 1'b1);
    fork
      applyStimulus(32'h5, 32'h15, 32'hC0, 1'b0);
      begin
        @(negedge clk);
        checkOutput("bp_in_ready_low", W'(in_ready), W'(0));
        checkOutput("bp_out_valid", W'(out_valid), W'(1));
        checkOutput("bp_nx_first", nx, 64'h00000002_00000001);
        repeat (3) @(negedge clk);
        checkOutput("bp_nx_frozen", nx, 64'h00000002_00000001);
        checkOutput("bp_in_ready_held", W'(in_ready), W'(0));
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_in_ready_back", W'(in_ready), W'(1));
        checkOutput("bp_nx_second", nx, 64'h00000004_00000003);
      end
    join
    applyStimulus(32'h6, 32'h16, 32'hC0, 1'b1);
    goIdle(4);
    checkOutput("bp_all_drained", W'(scoreboard.size()), W'(0));

    // Sustained throughput: one beat per cycle, never stalled.
    stalls = 0;
    xferStart = transfers;
    for (int k = 0; k < 10; k++) begin
      logic [N-1:0] x0;
      logic [N-1:0] x1;
      x0 = N'(32'h00010000 * (2 * k + 1));
      x1 = N'(32'h00010000 * (2 * k + 2));
      pushExp({x1, x0}, {~x1, ~x0}, N'(k));
      applyStimulus(x0, ~x0, N'(k), 1'b0);
      applyStimulus(x1, ~x1, N'(k), 1'b1);
    end
    goIdle(4);
    checkOutput("tput_stalls", W'(stalls), W'(0));
    checkOutput("tput_transfers", W'(transfers - xferStart), W'(10));

    // Missing in_last: beats 2..4 are dropped, then a clean vector follows.
    stalls = 0;
    errStart = errPulses;
    xferStart = transfers;
    for (int j = 0; j < 5; j++) bx[j] = N'(32'h00100000 * (j + 1));
    pushExp({bx[1], bx[0]}, {-bx[1], -bx[0]}, 32'h00000055);
    for (int j = 0; j < 5; j++) applyStimulus(bx[j], -bx[j], 32'h00000055, j == 4);
    pushExp(64'h0AAA0000_05550000, 64'h00330000_00220000, 32'h00000066);
    applyStimulus(32'h05550000, 32'h00220000, 32'h00000066, 1'b0);
    applyStimulus(32'h0AAA0000, 32'h00330000, 32'h00000066, 1'b1);
    goIdle(4);
    checkOutput("drop_err_pulses", W'(errPulses - errStart), W'(1));
    checkOutput("drop_in_ready", W'(stalls), W'(0));
    checkOutput("drop_transfers", W'(transfers - xferStart), W'(2));

    // Reset with one vector held and another half written.
    out_ready = 1'b0;
    applyStimulus(32'h11110000, 32'h22220000, 32'h33330000, 1'b0);
    applyStimulus(32'h44440000, 32'h55550000, 32'h33330000, 1'b1);
    applyStimulus(32'h66660000, 32'h77770000, 32'h88880000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("prerst_nx", nx, 64'h44440000_11110000);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", W'(out_valid), W'(0));
    checkOutput("rst_in_ready", W'(in_ready), W'(1));
    checkOutput("rst_nx", nx, '0);
    checkOutput("rst_nw", nw, '0);
    checkOutput("rst_b", W'(b), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    pushExp(64'h0BBB0000_0AAA0000, 64'h0DDD0000_0CCC0000, 32'h0EEE0000);
    applyStimulus(32'h0AAA0000, 32'h0CCC0000, 32'h0EEE0000, 1'b0);
    applyStimulus(32'h0BBB0000, 32'h0DDD0000, 32'h0FFF0000, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    checkOutput("postrst_out_valid", W'(out_valid), W'(1));
    checkOutput("postrst_nx", nx, 64'h0BBB0000_0AAA0000);
    checkOutput("postrst_nw", nw, 64'h0DDD0000_0CCC0000);
    goIdle(3);
    checkOutput("final_drained", W'(scoreboard.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
